// File: rtl/nios_design_pll_lock_sequencer_if.sv
// ---------------------------------------------------------------------------
// nios_design_pll_lock_sequencer_if
//   Groups the signals between the PLL lock sequencer and the PLL / system
//   side. Clock (refclk) and reset (rst) are plain module ports, not members.
//
//   Members:
//     pll_locked       PLL lock flag, asynchronous to refclk
//     recal_req        request to re-sequence the PLL (pulse or level)
//     pll_rst          reset to the PLL
//     sys_rst          active-high reset for logic on the PLL output clock
//     ready            1 only while the PLL is locked and qualified (RUN)
//     fault            1 only after too many lock timeouts (FAULT)
//     retry_count      timed-out attempts since last success or recal
//     lock_loss_count  RUN -> loss-of-lock events, saturating at 255
//
//   Modports:
//     master  the sequencer (drives resets/status, samples lock/request)
//     slave   the PLL / software side (drives lock/request)
//
//   Handshake: there is no valid/ready transfer on this interface. recal_req
//   is sampled on every rising refclk edge and acts in the cycle it is high;
//   holding it high simply repeats the request. pll_locked is a level.
// ---------------------------------------------------------------------------
interface nios_design_pll_lock_sequencer_if;
    logic       pll_locked;
    logic       recal_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    modport master (
        input  pll_locked,
        input  recal_req,
        output pll_rst,
        output sys_rst,
        output ready,
        output fault,
        output retry_count,
        output lock_loss_count
    );

    modport slave (
        output pll_locked,
        output recal_req,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  fault,
        input  retry_count,
        input  lock_loss_count
    );
endinterface

// File: rtl/nios_design_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// nios_design_pll_lock_sequencer
//   Sequences the system PLL from the free-running reference clock: pulses
//   the PLL reset, waits for a stable synchronized lock, then releases the
//   system reset. A lock timeout retries the sequence; too many timeouts
//   latch FAULT. Loss of lock in RUN or a software request re-sequences.
//
//   Ports:
//     refclk   in   reference clock, the only clock (rising edge)
//     rst      in   synchronous active-high reset
//     seq_if   master modport of nios_design_pll_lock_sequencer_if
//     state_o  out  current FSM state (debug visibility only)
//
//   All status outputs are flops loaded from the next state, so they change
//   on the same edge as the state register and never glitch.
// ---------------------------------------------------------------------------
module nios_design_pll_lock_sequencer #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned SYNC_STAGES         = 2
) (
    input  logic                                   refclk,
    input  logic                                   rst,
    nios_design_pll_lock_sequencer_if.master       seq_if,
    output logic [1:0]                             state_o
);

    localparam int unsigned PULSE_W  = $clog2(RST_PULSE_CYCLES + 1);
    localparam int unsigned STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned TMO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);

    // Terminal values: each counter holds "cycles already spent" so the last
    // cycle of a phase is the one where the counter equals N-1.
    localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(RST_PULSE_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]          RETRY_MAX   = 4'(MAX_RETRIES);

    typedef enum logic [1:0] {
        ST_RESET_PLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [PULSE_W-1:0]      pulse_q, pulse_d;
    logic [STABLE_W-1:0]     stable_q, stable_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [3:0]              retry_q, retry_d;
    logic [7:0]              loss_q, loss_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    locked_s;

    logic                    pll_rst_q;
    logic                    sys_rst_q;
    logic                    ready_q;
    logic                    fault_q;

    // pll_locked crosses into refclk here; nothing else looks at the raw pin.
    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], seq_if.pll_locked};
        end
    end

    // -----------------------------------------------------------------------
    // State and counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_RESET_PLL;
            pulse_q   <= '0;
            stable_q  <= '0;
            tmo_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pulse_q   <= pulse_d;
            stable_q  <= stable_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
            sys_rst_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
            fault_q   <= (state_d == ST_FAULT);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    //   Counters default to zero and only run inside their own state, so
    //   every counter is clear when its state is entered and cannot wrap.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pulse_d  = '0;
        stable_d = '0;
        tmo_d    = '0;
        retry_d  = retry_q;
        loss_d   = loss_q;

        // A loss of lock in RUN is counted even when a recal request arrives
        // in the same cycle.
        if ((state_q == ST_RUN) && !locked_s && (loss_q != 8'hFF)) begin
            loss_d = loss_q + 8'd1;
        end

        if (seq_if.recal_req) begin
            // pulse_d stays 0, so a held request keeps restarting the pulse.
            state_d = ST_RESET_PLL;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_RESET_PLL: begin
                    if (pulse_q == PULSE_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        pulse_d = pulse_q + 1'b1;
                    end
                end

                ST_WAIT_LOCK: begin
                    stable_d = locked_s ? (stable_q + 1'b1) : '0;
                    tmo_d    = tmo_q + 1'b1;
                    // Stable completion is tested first so it beats a
                    // timeout landing in the same cycle.
                    if (locked_s && (stable_q == STABLE_LAST)) begin
                        state_d = ST_RUN;
                        retry_d = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        retry_d = retry_q + 4'd1;
                        state_d = ((retry_q + 4'd1) == RETRY_MAX) ? ST_FAULT
                                                                  : ST_RESET_PLL;
                    end
                end

                ST_RUN: begin
                    if (!locked_s) begin
                        state_d = ST_RESET_PLL;
                    end
                end

                ST_FAULT: begin
                    state_d = ST_FAULT;
                end

                default: begin
                    state_d = ST_RESET_PLL;
                end
            endcase
        end
    end

    assign seq_if.pll_rst         = pll_rst_q;
    assign seq_if.sys_rst         = sys_rst_q;
    assign seq_if.ready           = ready_q;
    assign seq_if.fault           = fault_q;
    assign seq_if.retry_count     = retry_q;
    assign seq_if.lock_loss_count = loss_q;
    assign state_o                = state_q;

endmodule

// File: tb/tb_nios_design_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_nios_design_pll_lock_sequencer
//   Directed scenarios plus a randomized phase. A behavioural model tracks
//   the sequencer's phase with plain counters and a queue standing in for
//   the lock synchronizer; every DUT output is compared after every edge.
// ---------------------------------------------------------------------------
module tb_nios_design_pll_lock_sequencer;

    localparam int RST_PULSE = 4;
    localparam int STABLE    = 8;
    localparam int TIMEOUT   = 64;
    localparam int MAXR      = 2;
    localparam int SYNC      = 2;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic refclk = 1'b0;
    logic rst;
    logic pll_locked_drv;
    logic recal_drv;
    logic [1:0] dbg_state;

    always #5 refclk = ~refclk;

    nios_design_pll_lock_sequencer_if bus ();

    assign bus.pll_locked = pll_locked_drv;
    assign bus.recal_req  = recal_drv;

    nios_design_pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (RST_PULSE),
        .LOCK_STABLE_CYCLES  (STABLE),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRIES         (MAXR),
        .SYNC_STAGES         (SYNC)
    ) dut (
        .refclk  (refclk),
        .rst     (rst),
        .seq_if  (bus.master),
        .state_o (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard counters and checker
    // ------------------------------------------------------------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase names, cycles spent in the phase, and a queue
    // holding the last SYNC lock samples (front = what the logic sees).
    // ------------------------------------------------------------------
    localparam int P_PULSE = 0;
    localparam int P_WAIT  = 1;
    localparam int P_RUN   = 2;
    localparam int P_FAULT = 3;

    int   m_phase;
    int   m_pulse_done;
    int   m_locked_run;
    int   m_waited;
    int   m_retries;
    int   m_losses;
    logic m_sync[$];

    task automatic model_reset();
        m_phase      = P_PULSE;
        m_pulse_done = 0;
        m_locked_run = 0;
        m_waited     = 0;
        m_retries    = 0;
        m_losses     = 0;
        m_sync.delete();
        for (int i = 0; i < SYNC; i++) m_sync.push_back(1'b0);
    endtask

    task automatic start_pulse();
        m_phase      = P_PULSE;
        m_pulse_done = 0;
    endtask

    // Applies one rising edge to the model using the inputs held across it.
    task automatic model_edge();
        logic seen;
        if (rst) begin
            model_reset();
        end else begin
            seen = m_sync.pop_front();
            m_sync.push_back(pll_locked_drv);
            if (m_phase == P_RUN && !seen && m_losses < 255) m_losses++;
            if (recal_drv) begin
                start_pulse();
                m_retries = 0;
            end else begin
                case (m_phase)
                    P_PULSE: begin
                        m_pulse_done++;
                        if (m_pulse_done == RST_PULSE) begin
                            m_phase      = P_WAIT;
                            m_locked_run = 0;
                            m_waited     = 0;
                        end
                    end
                    P_WAIT: begin
                        m_waited++;
                        m_locked_run = seen ? m_locked_run + 1 : 0;
                        if (m_locked_run == STABLE) begin
                            m_phase   = P_RUN;
                            m_retries = 0;
                        end else if (m_waited == TIMEOUT) begin
                            m_retries++;
                            if (m_retries == MAXR) m_phase = P_FAULT;
                            else start_pulse();
                        end
                    end
                    P_RUN: begin
                        if (!seen) start_pulse();
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic compare_all();
        check("pll_rst", 32'(bus.pll_rst), 32'(m_phase == P_PULSE || m_phase == P_FAULT));
        check("sys_rst", 32'(bus.sys_rst), 32'(m_phase != P_RUN));
        check("ready",   32'(bus.ready),   32'(m_phase == P_RUN));
        check("fault",   32'(bus.fault),   32'(m_phase == P_FAULT));
        check("retry_count",     32'(bus.retry_count),     32'(m_retries));
        check("lock_loss_count", 32'(bus.lock_loss_count), 32'(m_losses));
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge refclk);
        model_edge();
        #1;
        compare_all();
    endtask

    // Steps until ready matches want; n = edges taken, -1 on budget expiry.
    task automatic wait_ready(input logic want, input int budget, input string tag, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (bus.ready === want) begin
                n = i;
                break;
            end
        end
        if (n < 0) check({tag, "_timeout"}, 32'(bus.ready), 32'(want));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        recal_drv = 1'b0;
        repeat (2) step();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        int seg_len;
        int seg_mode;

        rst            = 1'b1;
        recal_drv      = 1'b0;
        pll_locked_drv = 1'b1;
        model_reset();
        repeat (3) step();

        // Reset values
        check("rst_pll_rst", 32'(bus.pll_rst), 1);
        check("rst_sys_rst", 32'(bus.sys_rst), 1);
        check("rst_ready",   32'(bus.ready),   0);
        check("rst_fault",   32'(bus.fault),   0);

        // 1: clean lock -> RUN 4 + 2 + 8 - 2 = 12 edges after release
        rst = 1'b0;
        wait_ready(1'b1, 100, "t1", n);
        check("t1_run_latency", 32'(n), 12);
        check("t1_retry", 32'(bus.retry_count), 0);

        // 2: one-cycle dropout after 5 stable WAIT cycles delays RUN by 6
        do_reset();
        rst = 1'b0;
        repeat (7) step();
        pll_locked_drv = 1'b0;
        step();
        pll_locked_drv = 1'b1;
        wait_ready(1'b1, 100, "t2", n);
        check("t2_run_latency", 32'(n + 8), 18);
        check("t2_loss", 32'(bus.lock_loss_count), 0);

        // 3: never locks -> retry after 64 WAIT cycles, FAULT after the 2nd
        do_reset();
        pll_locked_drv = 1'b0;
        rst = 1'b0;
        repeat (67) step();
        check("t3_before_retry_pll_rst", 32'(bus.pll_rst), 0);
        step();
        check("t3_retry1", 32'(bus.retry_count), 1);
        check("t3_retry1_pll_rst", 32'(bus.pll_rst), 1);
        repeat (67) step();
        check("t3_before_fault", 32'(bus.fault), 0);
        step();
        check("t3_fault", 32'(bus.fault), 1);
        check("t3_retry2", 32'(bus.retry_count), 2);
        repeat (200) step();
        check("t3_fault_held", 32'(bus.fault), 1);
        check("t3_sys_rst_held", 32'(bus.sys_rst), 1);

        // 5: recal out of FAULT, then a normal lock
        recal_drv = 1'b1;
        step();
        recal_drv = 1'b0;
        check("t5_fault_clear", 32'(bus.fault), 0);
        check("t5_retry_clear", 32'(bus.retry_count), 0);
        check("t5_pll_rst", 32'(bus.pll_rst), 1);
        pll_locked_drv = 1'b1;
        wait_ready(1'b1, 100, "t5", n);

        // 4: loss of lock in RUN, then saturate the loss counter
        pll_locked_drv = 1'b0;
        wait_ready(1'b0, 10, "t4_drop", n);
        check("t4_loss1", 32'(bus.lock_loss_count), 1);
        check("t4_pll_rst", 32'(bus.pll_rst), 1);
        pll_locked_drv = 1'b1;
        wait_ready(1'b1, 100, "t4_relock", n);
        for (int i = 0; i < 299; i++) begin
            pll_locked_drv = 1'b0;
            wait_ready(1'b0, 10, "t4_loop_drop", n);
            pll_locked_drv = 1'b1;
            wait_ready(1'b1, 100, "t4_loop_relock", n);
            if (i == 253) check("t4_loss255", 32'(bus.lock_loss_count), 255);
        end
        check("t4_loss_sat", 32'(bus.lock_loss_count), 255);

        // 6: rst mid-WAIT_LOCK, then rst in RUN
        pll_locked_drv = 1'b0;
        repeat (15) step();
        rst = 1'b1;
        step();
        check("t6w_pll_rst", 32'(bus.pll_rst), 1);
        check("t6w_ready",   32'(bus.ready),   0);
        check("t6w_loss",    32'(bus.lock_loss_count), 0);
        pll_locked_drv = 1'b1;
        rst = 1'b0;
        wait_ready(1'b1, 100, "t6", n);
        check("t6_run_latency", 32'(n), 12);
        rst = 1'b1;
        step();
        check("t6r_sys_rst", 32'(bus.sys_rst), 1);
        check("t6r_ready",   32'(bus.ready),   0);
        rst = 1'b0;

        // Randomized phase: segments of steady/noisy lock, stray requests
        for (int s = 0; s < 120; s++) begin
            seg_len  = $urandom_range(1, 90);
            seg_mode = $urandom_range(0, 3);
            for (int c = 0; c < seg_len; c++) begin
                case (seg_mode)
                    0:       pll_locked_drv = 1'b1;
                    1:       pll_locked_drv = 1'b0;
                    2:       pll_locked_drv = ($urandom_range(0, 15) != 0);
                    default: pll_locked_drv = 1'($urandom_range(0, 1));
                endcase
                recal_drv = ($urandom_range(0, 99) == 0);
                rst       = ($urandom_range(0, 499) == 0);
                step();
            end
        end
        rst       = 1'b0;
        recal_drv = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
